// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types, constants and helpers for the instruction-fetch sequencer.
package imem_fetch_ctrl_pkg;

  localparam int unsigned INSTR_W           = 32;
  localparam int unsigned MEM_BYTES_DEFAULT = 4096;
  localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } fetch_state_e;

  // One buffered fetch: the byte PC of the request and the word returned for it.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // A redirect target is usable only if word aligned and inside imem.
  function automatic logic pc_is_legal(input logic [31:0] pc, input int unsigned mem_bytes);
    return (pc[1:0] == 2'b00) && (pc < mem_bytes);
  endfunction

  // Sequential fetch address, wrapping back to zero at the end of imem.
  function automatic logic [31:0] pc_next(input logic [31:0] pc, input int unsigned mem_bytes);
    logic [31:0] inc;
    inc = pc + 32'd4;
    return (inc == mem_bytes) ? 32'h0000_0000 : inc;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fetch_buf.sv
// Circular fetch buffer of {pc, instr} entries with head/tail pointers and a count.
// Flush empties the buffer and overrides a push in the same cycle.
module imem_fetch_ctrl_fetch_buf
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  fetch_entry_t                   push_entry,
  input  logic                           pop,
  input  logic                           flush,
  output logic [$clog2(DEPTH + 1)-1:0]   count,
  output fetch_entry_t                   head
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;
  logic             full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push && !flush;
  assign do_pop  = pop && (count_q != '0) && !flush;
  assign count   = count_q;
  assign head    = mem_q[head_q];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        tail_q <= ptr_inc(tail_q);
      end
      if (do_pop) begin
        head_q <= ptr_inc(head_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Entry storage; reset contents make the empty head read as {RESET_PC, NOP}.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '{pc: RESET_PC, instr: NOP_INSTR};
      end
    end else if (do_push) begin
      mem_q[tail_q] <= push_entry;
    end
  end

  // The issue throttle in the sequencer guarantees room for every returning word.
  push_into_full_a : assert property (@(posedge clk) disable iff (!reset) !(do_push && full));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem read per cycle, buffers
// returning words and hands them to decode over valid/ready. Redirects reload the PC and
// flush stale fetches; an illegal redirect target parks the block in a sticky fault.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned ADDR_W    = $clog2(MEM_BYTES / 4),
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic               fault
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e     state_q;
  logic [31:0]      fetch_pc_q;
  logic [31:0]      req_pc_q;
  logic             inflight_q;
  logic             fault_q;

  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     buf_head;
  fetch_entry_t     push_entry;
  logic             buf_push;
  logic             buf_pop;
  logic             buf_flush;
  logic             redirect_legal;
  logic             redirect_taken;
  int unsigned      occupancy;

  assign redirect_legal = pc_is_legal(redirect_pc, MEM_BYTES);
  // Redirects are ignored once faulted; the buffer is already empty then.
  assign redirect_taken = redirect_valid && (state_q != FAULT);

  // Issue throttle: room must exist for everything buffered plus the word in flight.
  // out_ready is intentionally not used so decode never sees a path into imem_en.
  always_comb begin
    occupancy = 32'(buf_count) + 32'(inflight_q);
    imem_en   = (state_q == RUN) && !redirect_valid && (occupancy < BUF_DEPTH);
  end

  assign imem_addr = fetch_pc_q[ADDR_W+1:2];

  // A returning word is dropped if a redirect lands in the same cycle.
  assign buf_push   = inflight_q && !redirect_valid;
  assign push_entry = '{pc: req_pc_q, instr: imem_instr};
  assign buf_pop    = out_valid && out_ready;
  assign buf_flush  = redirect_taken;

  // Sequencer FSM together with the PC, in-flight tracking and the sticky fault flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      inflight_q <= imem_en;
      if (imem_en) begin
        req_pc_q   <= fetch_pc_q;
        fetch_pc_q <= pc_next(fetch_pc_q, MEM_BYTES);
      end
      unique case (state_q)
        BOOT, RUN: begin
          state_q <= RUN;
          if (redirect_valid) begin
            if (redirect_legal) begin
              fetch_pc_q <= redirect_pc;
            end else begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end
          end
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q <= FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  imem_fetch_ctrl_fetch_buf #(
    .DEPTH    (BUF_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fetch_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (buf_push),
    .push_entry (push_entry),
    .pop        (buf_pop),
    .flush      (buf_flush),
    .count      (buf_count),
    .head       (buf_head)
  );

  assign out_valid = (buf_count != '0);
  assign out_instr = buf_head.instr;
  assign out_pc    = buf_head.pc;
  assign fault     = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized ready/redirect traffic,
// compared each cycle against a queue-based model of the fetch rules.
module tb_imem_fetch_ctrl;

  localparam int unsigned MemBytes = 4096;
  localparam int unsigned AddrW    = 10;
  localparam int unsigned BufDepth = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             imem_en;
  logic [AddrW-1:0] imem_addr;
  logic [31:0]      imem_instr;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic             fault;

  int n_assert = 0;
  int n_fail   = 0;
  string phase = "init";

  // Model state: fetch address, buffered PCs, PCs whose read is outstanding.
  bit          m_booted;
  bit          m_faulted;
  int unsigned m_pc;
  int unsigned m_q[$];
  int unsigned m_pend[$];

  int cyc;
  int first_en;
  int first_valid;

  always #5 clk = ~clk;

  // imem stub preloaded with mem[k] = 0x1000_0000 + k, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_instr <= 32'h1000_0000 + 32'(imem_addr);
  end

  imem_fetch_ctrl #(
    .MEM_BYTES (MemBytes),
    .ADDR_W    (AddrW),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (BufDepth)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=0x%08h expected=0x%08h", phase, name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_booted  = 1'b0;
    m_faulted = 1'b0;
    m_pc      = 0;
    m_q.delete();
    m_pend.delete();
  endtask

  task automatic check_reset_values();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0000_0000);
    check("rst_out_pc", out_pc, 32'h0000_0000);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_imem_en", 32'(imem_en), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
  endtask

  // One clock cycle: drive inputs mid-cycle, compare outputs, then advance the model
  // across the coming rising edge.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit          e_valid;
    bit          e_en;
    int unsigned ret_pc;
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    e_valid = (m_q.size() != 0);
    e_en    = m_booted && !m_faulted && !rv && ((m_q.size() + m_pend.size()) < int'(BufDepth));
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("imem_en", 32'(imem_en), 32'(e_en));
    check("imem_addr", 32'(imem_addr), m_pc >> 2);
    check("fault", 32'(fault), 32'(m_faulted));
    if (e_valid) begin
      check("out_pc", out_pc, m_q[0]);
      check("out_instr", out_instr, 32'h1000_0000 + (m_q[0] >> 2));
    end
    if (first_en < 0 && imem_en === 1'b1) first_en = cyc;
    if (first_valid < 0 && out_valid === 1'b1) first_valid = cyc;
    cyc++;
    // Handshake completes before any flush.
    if (e_valid && rdy) void'(m_q.pop_front());
    if (m_pend.size() != 0) begin
      ret_pc = m_pend.pop_front();
      if (!rv) m_q.push_back(ret_pc);
    end
    if (e_en) begin
      m_pend.push_back(m_pc);
      m_pc = (m_pc + 4) % MemBytes;
    end
    if (rv && !m_faulted) begin
      m_q.delete();
      if (rpc[1:0] == 2'b00 && rpc < MemBytes) m_pc = rpc;
      else m_faulted = 1'b1;
    end
    m_booted = 1'b1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    cyc            = 0;
    first_en       = -1;
    first_valid    = -1;
  endtask

  // Assert reset between clock edges, check outputs react at once, then release.
  task automatic async_reset_midcycle();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic random_steps(input int n);
    bit          rv;
    bit          rdy;
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFF0 + 32'(4 * $urandom_range(0, 3));
      else tgt = 32'(4 * $urandom_range(0, 1023));
      step(rv, tgt, rdy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    imem_instr     = 32'h0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    phase = "reset";
    check_reset_values();

    release_reset();
    phase = "startup";
    repeat (8) step(1'b0, 32'h0, 1'b1);
    check("first_imem_en_cycle", 32'(first_en), 32'd1);
    check("first_out_valid_cycle", 32'(first_valid), 32'd3);

    phase = "backpressure";
    repeat (6) step(1'b0, 32'h0, 1'b0);
    repeat (8) step(1'b0, 32'h0, 1'b1);

    phase = "redirect_pop";
    step(1'b1, 32'h0000_0040, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1);

    phase = "wrap";
    step(1'b1, 32'h0000_0FFC, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1);

    phase = "random";
    random_steps(400);

    phase = "fault_misaligned";
    repeat (3) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0042, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0000, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b1);

    phase = "fault_cleared";
    async_reset_midcycle();
    repeat (6) step(1'b0, 32'h0, 1'b1);

    phase = "fault_range";
    step(1'b1, 32'h0000_1000, 1'b0);
    repeat (2) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0000, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b1);

    phase = "async_reset";
    async_reset_midcycle();
    random_steps(30);
    async_reset_midcycle();
    repeat (8) step(1'b0, 32'h0, 1'b1);
    check("restart_first_out_valid_cycle", 32'(first_valid), 32'd3);

    phase = "random_tail";
    random_steps(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
